gfx_port_arbiter: RTL and testbench

GFX_PORT_ARBITER -- requirements
Module: gfx_port_arbiter

---
 rtl/m92_pkg.sv | 19 +
 rtl/gfx_port_arbiter_rr_pick.sv | 33 +++
 rtl/gfx_port_arbiter.sv | 81 ++++++++
 tb/tb_gfx_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m92_pkg.sv
// m92_pkg: shared types for the gfx port arbiter.
//   state_t    - arbiter FSM states (IDLE, BUSY)
//   N_REQ_DEF  - default requester count (tilemap layers A, B, C)
//   rr_index   - modular step used by the round-robin picker
package m92_pkg;

  localparam int N_REQ_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // (base + off) mod n, valid for base < n and off < n
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off >= n) ? base + off - n : base + off;
  endfunction

endpackage

// File: rtl/gfx_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   pending - per-requester pending flags
//   rr_ptr  - requester with highest priority this round
//   sel     - first pending requester at or after rr_ptr (wrapping)
//   valid   - at least one requester is pending
module rr_pick
  import m92_pkg::*;
#(
  parameter int N = N_REQ_DEF
) (
  input  logic [N-1:0] pending,
  input  logic [1:0]   rr_ptr,
  output logic [1:0]   sel,
  output logic         valid
);

  logic [1:0] idx;

  // Walk offsets from farthest to nearest so the nearest pending one wins.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = 2'(rr_index(int'(rr_ptr), k, N));
      if (pending[idx]) begin
        sel   = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gfx_port_arbiter.sv
// gfx_port_arbiter: shares one toggle-handshake SDRAM gfx port among
// N_REQ toggle-handshake requesters, round-robin.
//   clk_sys, reset_n     - clock, async active-low reset
//   req_i / ack_o        - per-requester toggle request / acknowledge
//   addr_i / data_o      - per-requester address in, read data out
//   sdr_req / sdr_ack    - toggle handshake to the SDRAM port
//   sdr_addr / sdr_q     - latched address out, read data in
//   busy, grant_id       - transfer outstanding, current/last grant
module gfx_port_arbiter
  import m92_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int AW    = 25,
  parameter int DW    = 32
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ*AW-1:0] addr_i,
  output logic [N_REQ-1:0]    ack_o,
  output logic [N_REQ*DW-1:0] data_o,
  output logic                sdr_req,
  output logic [AW-1:0]       sdr_addr,
  input  logic                sdr_ack,
  input  logic [DW-1:0]       sdr_q,
  output logic                busy,
  output logic [1:0]          grant_id
);

  state_t           state;
  logic [1:0]       rr_ptr;
  logic [N_REQ-1:0] pending;
  logic [1:0]       sel;
  logic             sel_vld;

  assign pending = req_i ^ ack_o;

  rr_pick #(.N(N_REQ)) u_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .sel     (sel),
    .valid   (sel_vld)
  );

  // sdr_ack == sdr_req means the port is free. In IDLE a mismatch is a
  // stale ack from a transfer abandoned by reset, so nothing is issued.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sdr_req  <= 1'b0;
      sdr_addr <= '0;
      ack_o    <= '0;
      data_o   <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld && (sdr_ack == sdr_req)) begin
            sdr_addr <= addr_i[sel*AW +: AW];
            sdr_req  <= ~sdr_req;
            grant_id <= sel;
            busy     <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (sdr_ack == sdr_req) begin
            data_o[grant_id*DW +: DW] <= sdr_q;
            ack_o[grant_id]           <= ~ack_o[grant_id];
            busy                      <= 1'b0;
            rr_ptr <= (grant_id == 2'(N_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_port_arbiter.sv
module tb_gfx_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 25;
  localparam int DW = 32;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_i;
  logic [N*AW-1:0]   addr_i;
  logic [N-1:0]      ack_o;
  logic [N*DW-1:0]   data_o;
  logic              sdr_req;
  logic [AW-1:0]     sdr_addr;
  logic              sdr_ack;
  logic [DW-1:0]     sdr_q;
  logic              busy;
  logic [1:0]        grant_id;

  int checks   = 0;
  int failures = 0;

  gfx_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .req_i    (req_i),
    .addr_i   (addr_i),
    .ack_o    (ack_o),
    .data_o   (data_o),
    .sdr_req  (sdr_req),
    .sdr_addr (sdr_addr),
    .sdr_ack  (sdr_ack),
    .sdr_q    (sdr_q),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] dslice(input int i);
    return data_o[i*DW +: DW];
  endfunction

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    req_i   = '0;
    sdr_ack = 1'b0;
    sdr_q   = '0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  // SDRAM-side responder for one transfer: wait (bounded) for an issue,
  // report the grant, answer after lat cycles with q.
  task automatic xfer(input int lat, input logic [DW-1:0] q, output logic [1:0] gid);
    int k;
    k = 0;
    while (sdr_req === sdr_ack && k < 20) begin
      @(negedge clk_sys);
      k++;
    end
    checks++;
    if (sdr_req === sdr_ack) begin
      failures++;
      $display("FAIL xfer_issue: sdr_req=%0b sdr_ack=%0b, required a toggle within 20 cycles", sdr_req, sdr_ack);
      gid = 2'd3;
      return;
    end
    gid = grant_id;
    repeat (lat) @(negedge clk_sys);
    sdr_q   = q;
    sdr_ack = sdr_req;
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_i   = '0;
    addr_i  = '0;
    sdr_ack = 1'b0;
    sdr_q   = '0;
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({sdr_req, busy, grant_id, ack_o} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctl: sdr_req=%0b busy=%0b grant_id=%0d ack_o=%b, required all 0", sdr_req, busy, grant_id, ack_o);
    end
    checks++;
    if (data_o !== '0 || sdr_addr !== '0) begin
      failures++;
      $display("FAIL reset_data: data_o=%h sdr_addr=%h, required 0", data_o, sdr_addr);
    end
    checks++;
    if (dut.rr_ptr !== 2'd0) begin
      failures++;
      $display("FAIL reset_rr_ptr: got %0d, required 0", dut.rr_ptr);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    checks++;
    if (sdr_req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_quiet: sdr_req=%0b busy=%0b, required 0 0", sdr_req, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    addr_i[1*AW +: AW] = 25'h0123456;
    req_i[1] = ~req_i[1];
    @(negedge clk_sys);
    checks++;
    if (sdr_addr !== 25'h0123456 || sdr_req !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd1) begin
      failures++;
      $display("FAIL single_issue: sdr_addr=%h sdr_req=%0b busy=%0b grant_id=%0d, required 0123456 1 1 1", sdr_addr, sdr_req, busy, grant_id);
    end
    repeat (4) @(negedge clk_sys);
    checks++;
    if (busy !== 1'b1 || ack_o !== 3'b000 || sdr_req !== 1'b1) begin
      failures++;
      $display("FAIL single_wait: busy=%0b ack_o=%b sdr_req=%0b, required 1 000 1", busy, ack_o, sdr_req);
    end
    sdr_q   = 32'hDEADBEEF;
    sdr_ack = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (dslice(1) !== 32'hDEADBEEF || ack_o !== 3'b010 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done: data1=%h ack_o=%b busy=%0b, required deadbeef 010 0", dslice(1), ack_o, busy);
    end
    checks++;
    if (dslice(0) !== 32'h0 || dslice(2) !== 32'h0) begin
      failures++;
      $display("FAIL single_hold: data0=%h data2=%h, required 0 0", dslice(0), dslice(2));
    end
  endtask

  task automatic test_all_three();
    logic [1:0] g;
    do_reset();
    req_i = 3'b111;
    for (int t = 0; t < 3; t++) begin
      xfer(1, 32'hA000_0000 + 32'(t), g);
      checks++;
      if (g !== 2'(t)) begin
        failures++;
        $display("FAIL all3_order[%0d]: grant=%0d, required %0d", t, g, t);
      end
    end
    checks++;
    if (ack_o !== 3'b111 || busy !== 1'b0) begin
      failures++;
      $display("FAIL all3_ack: ack_o=%b busy=%0b, required 111 0", ack_o, busy);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dslice(i) !== 32'hA000_0000 + 32'(i)) begin
        failures++;
        $display("FAIL all3_data[%0d]: got %h, required %h", i, dslice(i), 32'hA000_0000 + 32'(i));
      end
    end
    checks++;
    if (dut.rr_ptr !== 2'd0) begin
      failures++;
      $display("FAIL all3_rr_ptr: got %0d, required 0", dut.rr_ptr);
    end
  endtask

  task automatic test_starvation();
    logic [1:0] g;
    int exp_g[3] = '{0, 2, 0};
    do_reset();
    req_i[0] = 1'b1;
    req_i[2] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      xfer(0, 32'h5000_0000 + 32'(t), g);
      checks++;
      if (g !== 2'(exp_g[t])) begin
        failures++;
        $display("FAIL starve_order[%0d]: grant=%0d, required %0d", t, g, exp_g[t]);
      end
      if (g == 2'd0 && t < 2) req_i[0] = ~req_i[0];
    end
    @(negedge clk_sys);
    checks++;
    if (ack_o !== req_i || busy !== 1'b0) begin
      failures++;
      $display("FAIL starve_quiet: ack_o=%b req_i=%b busy=%0b, required ack_o==req_i busy 0", ack_o, req_i, busy);
    end
  endtask

  task automatic test_addr_hold();
    do_reset();
    addr_i[0 +: AW] = 25'h1ABCDEF;
    req_i[0] = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (sdr_addr !== 25'h1ABCDEF || busy !== 1'b1) begin
      failures++;
      $display("FAIL addr_issue: sdr_addr=%h busy=%0b, required 1abcdef 1", sdr_addr, busy);
    end
    addr_i[0 +: AW] = 25'h0555555;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (sdr_addr !== 25'h1ABCDEF) begin
      failures++;
      $display("FAIL addr_hold_busy: sdr_addr=%h, required 1abcdef", sdr_addr);
    end
    sdr_q   = 32'h5A5A_5A5A;
    sdr_ack = sdr_req;
    @(negedge clk_sys);
    checks++;
    if (sdr_addr !== 25'h1ABCDEF || ack_o !== 3'b001 || dslice(0) !== 32'h5A5A_5A5A) begin
      failures++;
      $display("FAIL addr_done: sdr_addr=%h ack_o=%b data0=%h, required 1abcdef 001 5a5a5a5a", sdr_addr, ack_o, dslice(0));
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    req_i[1] = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (sdr_req !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstbusy_issue: sdr_req=%0b busy=%0b, required 1 1", sdr_req, busy);
    end
    reset_n = 1'b0;
    req_i   = '0;
    @(negedge clk_sys);
    checks++;
    if (sdr_req !== 1'b0 || busy !== 1'b0 || ack_o !== 3'b000) begin
      failures++;
      $display("FAIL rstbusy_reset: sdr_req=%0b busy=%0b ack_o=%b, required 0 0 000", sdr_req, busy, ack_o);
    end
    reset_n  = 1'b1;
    sdr_ack  = 1'b1;   // late ack of the abandoned transfer
    req_i[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_sys);
      checks++;
      if (sdr_req !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rstbusy_stale[%0d]: sdr_req=%0b busy=%0b, required 0 0", c, sdr_req, busy);
      end
    end
    sdr_ack = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (sdr_req !== 1'b1 || grant_id !== 2'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstbusy_issue2: sdr_req=%0b grant_id=%0d busy=%0b, required 1 2 1", sdr_req, grant_id, busy);
    end
    sdr_q   = 32'hC0FFEE00;
    sdr_ack = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (ack_o !== 3'b100 || dslice(2) !== 32'hC0FFEE00) begin
      failures++;
      $display("FAIL rstbusy_done: ack_o=%b data2=%h, required 100 c0ffee00", ack_o, dslice(2));
    end
  endtask

  task automatic test_back_to_back();
    int   tog_at[$];
    logic prev;
    do_reset();
    req_i = 3'b111;
    prev  = sdr_req;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_sys);
      if (sdr_req !== prev) begin
        tog_at.push_back(c);
        prev = sdr_req;
      end
      if (sdr_req !== sdr_ack) begin
        sdr_q   = 32'hB0 + 32'(grant_id);
        sdr_ack = sdr_req;
      end
    end
    checks++;
    if (tog_at.size() != 3) begin
      failures++;
      $display("FAIL b2b_count: toggles=%0d, required 3", tog_at.size());
    end else begin
      checks++;
      if (tog_at[0] != 1 || tog_at[1] - tog_at[0] != 2 || tog_at[2] - tog_at[1] != 2) begin
        failures++;
        $display("FAIL b2b_spacing: toggles at %0d %0d %0d, required 1 3 5", tog_at[0], tog_at[1], tog_at[2]);
      end
    end
    checks++;
    if (ack_o !== 3'b111 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ack: ack_o=%b busy=%0b, required 111 0", ack_o, busy);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dslice(i) !== 32'hB0 + 32'(i)) begin
        failures++;
        $display("FAIL b2b_data[%0d]: got %h, required %h", i, dslice(i), 32'hB0 + 32'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_starvation();
    test_addr_hold();
    test_reset_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
